seq_divider: RTL and testbench
==============================

# seq_divider

Sequential shift-subtract divider, the inverse companion of the Booth multiplier datapath: accepts a 16-bit dividend and 8-bit divisor on a `valid` pulse and returns an 8-bit quotient and remainder after a fixed number of cycles. It is controlled by a dedicated FSM with a `done` pulse, and flags divide-by-zero and quotient overflow. Its 16-bit dividend input matches the multiplier's `Y` output width, so products can be fed back for round-trip checks.

## Interface
- `N`, default 8: divisor, quotient and remainder width. Dividend is 2N bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `valid` input 1: start request. Sampled only in IDLE.
- `D` input 2N: dividend.
- `B` input N: divisor.
- `busy` output 1: high from CHECK through DONE.
- `done` output 1: one-cycle pulse when results are valid.
- `Q` output N: quotient.
- `R` output N: remainder.
- `div_zero` output 1: divisor was zero.
- `overflow` output 1: quotient does not fit in N bits.

## Operation
- States:
  - IDLE:
    - `valid`=1 captures `D` and `B` (magnitudes in signed mode) and goes to CHECK.
    - `valid`=0 stays in IDLE.
  - CHECK:
    - B==0 sets `div_zero` and goes to DONE.
    - Otherwise, high N bits of the dividend magnitude ≥ divisor magnitude sets `overflow` and goes to DONE.
    - Otherwise loads `rem` (N+1 bits) with the dividend high half, `q` with the low half, clears the counter, and goes to ITER.
  - ITER (N cycles):
    - Shift {rem,q} left by 1.
    - trial = rem − divisor. If trial ≥ 0: rem = trial, q[0] = 1. Else q[0] = 0.
    - Counter reaching N−1 goes to FIX.
  - FIX: sign correction (signed mode only; pass-through otherwise). Drives `Q`/`R` from `q`/`rem[N-1:0]`. Goes to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Error results: `Q`=all ones, `R`=0, with the corresponding flag high.
- `Q`, `R` and the flags hold their values until the next accepted `valid`. The flags clear on acceptance.
- `valid` while `busy` is ignored; there is no queueing.
- Divisor magnitude is held in N+1 bits so that −2^(N−1) is representable.

## Timing
- Reset values: state IDLE; `busy`, `done`, `div_zero`, `overflow` = 0; `Q`, `R` = 0.
- `valid` sampled at edge k:
  - Normal result: `done` high in cycle k+N+3 (11 cycles for N=8).
  - Error result: `done` high in cycle k+2.
- `busy` is high during cycles k+1 through the `done` cycle. It is low in the cycle after `done`, when a new `valid` may be accepted.
- `rst` mid-operation returns to IDLE and zeroes all outputs on the next edge. No `done` is produced.
- `valid` asserted in the same cycle as `done` is ignored.

## Configuration
- `DIV_SIGNED_EN` defined: operands are two's complement.
  - Magnitudes are divided.
  - Quotient sign = sign(D) xor sign(B); remainder sign = sign(D).
  - In FIX, `overflow` is set and the error result replaces Q/R when the magnitude quotient exceeds 2^(N−1)−1 (positive result) or 2^(N−1) (negative result).
- Undefined: unsigned operands. FIX is a pass-through, and the CHECK test is the only overflow source.

## Structure
- Package `div_pkg`:
  - state enum `div_state_t` (IDLE, CHECK, ITER, FIX, DONE);
  - constant `DIV_N` = 8;
  - the error-quotient constant.
- Sub-module `div_step`: combinational single iteration. It takes {rem,q} and the divisor, and returns the shifted/subtracted {rem,q}. The top holds the FSM, counter and registers.

## Test plan
- Unsigned: D=1000, B=7 → Q=142 (0x8E), R=6; `done` at k+11; flags 0.
- B=0 with any D → `div_zero`=1, Q=0xFF, R=0x00; `done` at k+2.
- Unsigned overflow: D=0x0800, B=0x08 → `overflow`=1, Q=0xFF, R=0; `done` at k+2.
- Signed (`DIV_SIGNED_EN`):
  - D=−100 (0xFF9C), B=7 → Q=0xF2 (−14), R=0xFE (−2).
  - D=16384, B=−128 → Q=0x80, R=0, no overflow.
  - D=−16384, B=−128 → `overflow`=1.
- `valid` pulsed during ITER → ignored; the first result is unchanged. `rst` asserted at cycle k+5 → IDLE, outputs 0, no `done`. A subsequent 1000/7 completes correctly.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential shift-subtract divider.
package div_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      ITER,
      FIX,
      DONE
   } div_state_t;

   localparam int unsigned DIV_N = 8;

   // Error quotient is all ones at any width; replicate this bit N times.
   localparam logic DIV_ERR_Q_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {rem,q} left, then conditionally subtract the divisor.
module div_step #(
   parameter int unsigned N = 8
) (
   input  logic [N:0]   rem,
   input  logic [N-1:0] q,
   input  logic [N:0]   div,
   output logic [N:0]   rem_next,
   output logic [N-1:0] q_next
);

   logic [N:0]   rem_s;
   logic [N+1:0] trial;

   always_comb begin
      rem_s = {rem[N-1:0], q[N-1]};
      trial = {1'b0, rem_s} - {1'b0, div};
      if (!trial[N+1]) begin
         rem_next = trial[N:0];
         q_next   = {q[N-2:0], 1'b1};
      end else begin
         rem_next = rem_s;
         q_next   = {q[N-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Sequential divider: 2N-bit dividend / N-bit divisor with div-by-zero and overflow flags.
// Define DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid,
   input  logic [2*N-1:0] D,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [N-1:0]   Q,
   output logic [N-1:0]   R,
   output logic           div_zero,
   output logic           overflow
);

   localparam int unsigned CNT_W = $clog2(N);

   div_state_t       state;
   logic [2*N-1:0]   d_mag;
   logic [N:0]       b_mag;
   logic [N:0]       rem;
   logic [N-1:0]     q;
   logic [CNT_W-1:0] cnt;
   logic [N:0]       rem_next;
   logic [N-1:0]     q_next;
`ifdef DIV_SIGNED_EN
   localparam logic [N-1:0] HALF = {1'b1, {(N-1){1'b0}}};
   logic sign_q;
   logic sign_r;
`endif

   div_step #(.N(N)) u_step (
      .rem      (rem),
      .q        (q),
      .div      (b_mag),
      .rem_next (rem_next),
      .q_next   (q_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         overflow <= 1'b0;
         Q        <= '0;
         R        <= '0;
         d_mag    <= '0;
         b_mag    <= '0;
         rem      <= '0;
         q        <= '0;
         cnt      <= '0;
`ifdef DIV_SIGNED_EN
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (valid) begin
`ifdef DIV_SIGNED_EN
                  d_mag  <= D[2*N-1] ? (~D + 1'b1) : D;
                  b_mag  <= B[N-1] ? (~{1'b1, B} + 1'b1) : {1'b0, B};
                  sign_q <= D[2*N-1] ^ B[N-1];
                  sign_r <= D[2*N-1];
`else
                  d_mag  <= D;
                  b_mag  <= {1'b0, B};
`endif
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  overflow <= 1'b0;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (b_mag == '0) begin
                  div_zero <= 1'b1;
                  Q        <= {N{DIV_ERR_Q_BIT}};
                  R        <= '0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else if ({1'b0, d_mag[2*N-1:N]} >= b_mag) begin
                  overflow <= 1'b1;
                  Q        <= {N{DIV_ERR_Q_BIT}};
                  R        <= '0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  rem   <= {1'b0, d_mag[2*N-1:N]};
                  q     <= d_mag[N-1:0];
                  cnt   <= '0;
                  state <= ITER;
               end
            end
            ITER: begin
               rem <= rem_next;
               q   <= q_next;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(N - 1))
                  state <= FIX;
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
               // A negative quotient may reach -2^(N-1); a positive one stops at 2^(N-1)-1.
               if (sign_q ? (q > HALF) : (q >= HALF)) begin
                  overflow <= 1'b1;
                  Q        <= {N{DIV_ERR_Q_BIT}};
                  R        <= '0;
               end else begin
                  Q <= sign_q ? (~q + 1'b1) : q;
                  R <= sign_r ? (~rem[N-1:0] + 1'b1) : rem[N-1:0];
               end
`else
               Q <= q;
               R <= rem[N-1:0];
`endif
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider; vectors follow DIV_SIGNED_EN like the RTL build.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [15:0] D;
   logic [7:0]  B;
   logic        busy;
   logic        done;
   logic [7:0]  Q;
   logic [7:0]  R;
   logic        div_zero;
   logic        overflow;

   seq_divider #(.N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid    (valid),
      .D        (D),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .Q        (Q),
      .R        (R),
      .div_zero (div_zero),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       dz;
      logic       ov;
      int         acc;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   done_count = 0;

   // Shared operand for the ignore/reset scenarios; must not overflow in either mode.
`ifdef DIV_SIGNED_EN
   localparam logic [15:0] T_D = 16'd100;
   localparam logic [7:0]  T_B = 8'd7;
   localparam logic [7:0]  T_Q = 8'd14;
   localparam logic [7:0]  T_R = 8'd2;
`else
   localparam logic [15:0] T_D = 16'd1000;
   localparam logic [7:0]  T_B = 8'd7;
   localparam logic [7:0]  T_Q = 8'h8E;
   localparam logic [7:0]  T_R = 8'd6;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency is counted in cycles with the accepting edge's cycle as 1.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_count <= done_count + 1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no result pending (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            check("Q", {24'd0, Q}, {24'd0, e.q});
            check("R", {24'd0, R}, {24'd0, e.r});
            check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            check("overflow", {31'd0, overflow}, {31'd0, e.ov});
            check("latency", cyc - e.acc + 1, e.lat);
            check("busy_at_done", {31'd0, busy}, 32'd1);
         end
      end
   end

   task automatic start(input logic [15:0] d, input logic [7:0] b, input logic push,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input int lat);
      exp_t e;
      @(negedge clk);
      D     = d;
      B     = b;
      valid = 1'b1;
      if (push) begin
         e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.acc = cyc + 1; e.lat = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 40 && !done; i++) @(negedge clk);
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 40 cycles");
      end
   endtask

   task automatic run(input logic [15:0] d, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eov, input int lat);
      start(d, b, 1'b1, eq, er, edz, eov, lat);
      wait_done();
      @(negedge clk);
      check("busy_after_done", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int dc;
      rst   = 1'b1;
      valid = 1'b0;
      D     = '0;
      B     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_Q", {24'd0, Q}, 32'd0);
      check("reset_R", {24'd0, R}, 32'd0);
      check("reset_flags", {30'd0, div_zero, overflow}, 32'd0);

`ifdef DIV_SIGNED_EN
      run(16'hFF9C, 8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 11);
      run(16'd16384, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 11);
      run(16'hC000, 8'h80,  8'hFF, 8'h00, 1'b0, 1'b1, 11);
      run(16'd1000, 8'd7,   8'hFF, 8'h00, 1'b0, 1'b1, 11);
      run(16'd100, 8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0, 11);
      run(16'd1016, 8'd8,   8'h7F, 8'h00, 1'b0, 1'b0, 11);
      run(16'hFC08, 8'd8,   8'h81, 8'h00, 1'b0, 1'b0, 11);
      run(16'h8000, 8'd1,   8'hFF, 8'h00, 1'b0, 1'b1, 2);
      run(16'h1234, 8'd0,   8'hFF, 8'h00, 1'b1, 1'b0, 2);
`else
      run(16'd1000, 8'd7,   8'h8E, 8'd6,  1'b0, 1'b0, 11);
      run(16'h1234, 8'd0,   8'hFF, 8'h00, 1'b1, 1'b0, 2);
      run(16'h0800, 8'h08,  8'hFF, 8'h00, 1'b0, 1'b1, 2);
      run(16'd255, 8'd16,   8'd15, 8'd15, 1'b0, 1'b0, 11);
      run(16'hFE01, 8'hFF,  8'hFF, 8'h00, 1'b0, 1'b0, 11);
      run(16'hFFFF, 8'hFF,  8'hFF, 8'h00, 1'b0, 1'b1, 2);
      run(16'd0, 8'd5,      8'h00, 8'h00, 1'b0, 1'b0, 11);
      run(16'h07FF, 8'd8,   8'hFF, 8'd7,  1'b0, 1'b0, 11);
`endif

      // Results persist while idle.
      run(T_D, T_B, T_Q, T_R, 1'b0, 1'b0, 11);
      repeat (3) @(negedge clk);
      check("hold_Q", {24'd0, Q}, {24'd0, T_Q});
      check("hold_R", {24'd0, R}, {24'd0, T_R});

      // valid during ITER and in the done cycle must not start anything.
      dc = done_count;
      start(T_D, T_B, 1'b1, T_Q, T_R, 1'b0, 1'b0, 11);
      repeat (2) @(negedge clk);
      D     = 16'h0800;
      B     = 8'd0;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_done();
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check("busy_after_ignored_valid", {31'd0, busy}, 32'd0);
      repeat (15) @(negedge clk);
      check("ignored_valid_done_count", done_count - dc, 1);

      // Reset sampled at the fifth edge after acceptance aborts without done.
      dc = done_count;
      start(T_D, T_B, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_Q", {24'd0, Q}, 32'd0);
      check("abort_R", {24'd0, R}, 32'd0);
      check("abort_flags", {30'd0, div_zero, overflow}, 32'd0);
      repeat (15) @(negedge clk);
      check("abort_no_done", done_count - dc, 0);

      run(T_D, T_B, T_Q, T_R, 1'b0, 1'b0, 11);

      repeat (2) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running expected finish before 200000 time units");
      $fatal(1);
   end

endmodule
